// File: rtl/board_input_conditioner.sv
// Conditions raw board KEY/SW pins for the button and switch PIOs: two-flop sync,
// counter debounce, registered press/release pulses and per-button auto-repeat.
module board_input_conditioner #(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_BTN-1:0] key_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] button_export,
  output logic [N_SW-1:0]  switch_export,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);

  localparam int N_IN   = N_BTN + N_SW;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HC_W   = $clog2(HC_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0]  DELAY_LAST  = HC_W'(REPEAT_DELAY - 1);
  localparam logic [HC_W-1:0]  PERIOD_LAST = HC_W'(REPEAT_PERIOD - 1);
  // Buttons idle high (active-low KEY), switches idle low.
  localparam logic [N_IN-1:0]  RST_VAL     = {{N_SW{1'b0}}, {N_BTN{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  logic [N_IN-1:0]  s1_q, s2_q, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];

  rep_state_e       state_q [N_BTN];
  rep_state_e       state_d [N_BTN];
  logic [HC_W-1:0]  hc_q [N_BTN];
  logic [HC_W-1:0]  hc_d [N_BTN];

  logic [N_BTN-1:0] fall_s, rise_s, rep_s;
  logic [N_BTN-1:0] press_q, press_d, release_q, release_d;

  // Synchroniser, debounce counters and stable levels.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1_q     <= RST_VAL;
      s2_q     <= RST_VAL;
      stable_q <= RST_VAL;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= {sw_raw, key_raw};
      s2_q     <= s1_q;
      stable_q <= stable_d;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Per-bit debounce: accept s2 only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign fall_s = stable_q[N_BTN-1:0] & ~stable_d[N_BTN-1:0];
  assign rise_s = ~stable_q[N_BTN-1:0] & stable_d[N_BTN-1:0];

  // Auto-repeat next state; a release wins over a coincident repeat expiry.
  always_comb begin
    for (int b = 0; b < N_BTN; b++) begin
      state_d[b] = state_q[b];
      hc_d[b]    = hc_q[b];
      rep_s[b]   = 1'b0;
      case (state_q[b])
        ST_IDLE: begin
          if (fall_s[b]) begin
            state_d[b] = ST_DELAY;
            hc_d[b]    = '0;
          end else begin
            state_d[b] = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (rise_s[b]) begin
            state_d[b] = ST_IDLE;
            hc_d[b]    = '0;
          end else if (hc_q[b] == DELAY_LAST) begin
            rep_s[b]   = 1'b1;
            state_d[b] = ST_REPEAT;
            hc_d[b]    = '0;
          end else begin
            hc_d[b] = hc_q[b] + HC_W'(1);
          end
        end
        ST_REPEAT: begin
          if (rise_s[b]) begin
            state_d[b] = ST_IDLE;
            hc_d[b]    = '0;
          end else if (hc_q[b] == PERIOD_LAST) begin
            rep_s[b] = 1'b1;
            hc_d[b]  = '0;
          end else begin
            hc_d[b] = hc_q[b] + HC_W'(1);
          end
        end
        default: begin
          state_d[b] = ST_IDLE;
          hc_d[b]    = '0;
        end
      endcase
    end
  end

  assign press_d   = fall_s | rep_s;
  assign release_d = rise_s;

  // Repeat FSM state and registered pulse outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      press_q   <= '0;
      release_q <= '0;
      for (int b = 0; b < N_BTN; b++) begin
        state_q[b] <= ST_IDLE;
        hc_q[b]    <= '0;
      end
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      for (int b = 0; b < N_BTN; b++) begin
        state_q[b] <= state_d[b];
        hc_q[b]    <= hc_d[b];
      end
    end
  end

  assign button_export = stable_q[N_BTN-1:0];
  assign switch_export = stable_q[N_IN-1:N_BTN];
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner with short debounce/repeat timings.
// Loop index e is the edge just taken; inputs set before edge e are captured at it.
module tb_board_input_conditioner;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [3:0]  key_raw;
  logic [9:0]  sw_raw;
  logic [3:0]  button_export;
  logic [9:0]  switch_export;
  logic [3:0]  press_pulse;
  logic [3:0]  release_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_clk = ~clk_clk;

  board_input_conditioner #(
    .N_BTN(4), .N_SW(10), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .key_raw      (key_raw),
    .sw_raw       (sw_raw),
    .button_export(button_export),
    .switch_export(switch_export),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic apply_reset();
    key_raw       = 4'hF;
    sw_raw        = 10'h000;
    reset_reset_n = 1'b0;
    repeat (2) tick();
    reset_reset_n = 1'b1;
  endtask

  initial begin
    key_raw       = 4'hF;
    sw_raw        = 10'h000;
    reset_reset_n = 1'b0;
    #2;
    apply_reset();
    check("reset btn", 32'(button_export), 32'h0000_000F);
    check("reset sw", 32'(switch_export), 32'h0000_0000);
    check("reset press", 32'(press_pulse), 32'h0000_0000);
    check("reset release", 32'(release_pulse), 32'h0000_0000);

    // Clean press of key 0: export falls at edge 5, one press pulse.
    for (int e = 0; e <= 7; e++) begin
      if (e == 0) key_raw[0] = 1'b0;
      tick();
      check($sformatf("clean btn e%0d", e), 32'(button_export), (e >= 5) ? 32'h0000_000E : 32'h0000_000F);
      check($sformatf("clean press e%0d", e), 32'(press_pulse), (e == 5) ? 32'h0000_0001 : 32'h0000_0000);
      check($sformatf("clean rel e%0d", e), 32'(release_pulse), 32'h0000_0000);
      check($sformatf("clean sw e%0d", e), 32'(switch_export), 32'h0000_0000);
    end

    // Bouncing switch 3, final toggle to 1 captured at edge 20 -> accepted at edge 25.
    apply_reset();
    for (int e = 0; e <= 27; e++) begin
      if (e <= 20 && (e % 2) == 0) sw_raw[3] = ((e / 2) % 2 == 0);
      tick();
      check($sformatf("bounce sw e%0d", e), 32'(switch_export), (e >= 25) ? 32'h0000_0008 : 32'h0000_0000);
    end

    // Three-cycle glitch on key 2 is rejected.
    apply_reset();
    for (int e = 0; e <= 12; e++) begin
      if (e == 0) key_raw[2] = 1'b0;
      if (e == 3) key_raw[2] = 1'b1;
      tick();
      check($sformatf("glitch btn e%0d", e), 32'(button_export), 32'h0000_000F);
      check($sformatf("glitch press e%0d", e), 32'(press_pulse), 32'h0000_0000);
      check($sformatf("glitch rel e%0d", e), 32'(release_pulse), 32'h0000_0000);
    end

    // Auto-repeat on key 1: pulses after edges 5, 25, 30..60; release at 65 suppresses the repeat.
    apply_reset();
    for (int e = 0; e <= 70; e++) begin
      logic exp_p;
      if (e == 0)  key_raw[1] = 1'b0;
      if (e == 60) key_raw[1] = 1'b1;
      tick();
      exp_p = (e == 5) || (e == 25) || (e >= 30 && e <= 60 && ((e - 30) % 5) == 0);
      check($sformatf("repeat press e%0d", e), 32'(press_pulse), exp_p ? 32'h0000_0002 : 32'h0000_0000);
      check($sformatf("repeat rel e%0d", e), 32'(release_pulse), (e == 65) ? 32'h0000_0002 : 32'h0000_0000);
      check($sformatf("repeat btn e%0d", e), 32'(button_export),
            (e >= 5 && e < 65) ? 32'h0000_000D : 32'h0000_000F);
    end

    // All keys together, then release of keys 0 and 3 only.
    apply_reset();
    for (int e = 0; e <= 16; e++) begin
      if (e == 0)  key_raw = 4'h0;
      if (e == 10) key_raw = 4'h9;
      tick();
      check($sformatf("simul press e%0d", e), 32'(press_pulse), (e == 5) ? 32'h0000_000F : 32'h0000_0000);
      check($sformatf("simul rel e%0d", e), 32'(release_pulse), (e == 15) ? 32'h0000_0009 : 32'h0000_0000);
      check($sformatf("simul btn e%0d", e), 32'(button_export),
            (e < 5) ? 32'h0000_000F : ((e < 15) ? 32'h0000_0000 : 32'h0000_0009));
    end

    // Reset mid-count: key 1 and switch 0 accepted, key 0 at cnt=2 when reset hits.
    apply_reset();
    for (int e = 0; e <= 9; e++) begin
      if (e == 0) begin
        key_raw[1] = 1'b0;
        sw_raw[0]  = 1'b1;
      end
      if (e == 6) key_raw[0] = 1'b0;
      tick();
      if (e == 5) check("pre-rst press", 32'(press_pulse), 32'h0000_0002);
    end
    check("pre-rst btn", 32'(button_export), 32'h0000_000D);
    check("pre-rst sw", 32'(switch_export), 32'h0000_0001);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check("async rst btn", 32'(button_export), 32'h0000_000F);
    check("async rst sw", 32'(switch_export), 32'h0000_0000);
    check("async rst press", 32'(press_pulse), 32'h0000_0000);
    check("async rst rel", 32'(release_pulse), 32'h0000_0000);
    repeat (2) tick();
    reset_reset_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      check($sformatf("post-rst btn e%0d", e), 32'(button_export), (e >= 5) ? 32'h0000_000C : 32'h0000_000F);
      check($sformatf("post-rst sw e%0d", e), 32'(switch_export), (e >= 5) ? 32'h0000_0001 : 32'h0000_0000);
      check($sformatf("post-rst press e%0d", e), 32'(press_pulse), (e == 5) ? 32'h0000_0003 : 32'h0000_0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
